// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
// Line levels and the bit-counter sizing helper live here so the top and the bench agree.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  // The counter only has to reach DATA_W-1, so it never needs more than clog2(DATA_W) bits.
  function automatic int cnt_width(input int data_w);
    return (data_w <= 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/serial_frame_obuf.sv
// One-entry valid/ready holding register for received words.
// A load is accepted when empty or when popped at the same edge; otherwise it reports overrun.
module serial_frame_obuf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              pop,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              overrun
);

  logic accept;

  assign accept = load && (!valid || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load && valid && !pop;
      if (accept) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (valid && pop) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W bits MSB first, optional even parity, stop bit.
// Good words go to a one-entry output buffer; bad frames raise a one-cycle error pulse.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int              CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic              parity_ok;
  logic              load_req;
  logic              perr_d;
  logic              ferr_d;

  always_comb begin
    state_d   = state_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    load_req  = 1'b0;
    parity_ok = PARITY_EN ? ~par_q : 1'b1;
    case (state_q)
      IDLE:   if (din == START_BIT) state_d = DATA;
      DATA:   if (cnt_q == LAST_BIT) state_d = PARITY_EN ? PARITY : STOP;
      PARITY: state_d = STOP;
      STOP: begin
        // Framing beats parity beats overrun; exactly one outcome per frame.
        state_d = IDLE;
        if (din != STOP_BIT)  ferr_d   = 1'b1;
        else if (!parity_ok)  perr_d   = 1'b1;
        else                  load_req = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          par_q <= 1'b0;
        end
        DATA: begin
          shift_q <= {shift_q[DATA_W-2:0], din};
          cnt_q   <= cnt_q + CNT_W'(1);
          par_q   <= par_q ^ din;
        end
        PARITY: par_q <= par_q ^ din;
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  serial_frame_obuf #(.DATA_W(DATA_W)) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .load      (load_req),
    .load_data (shift_q),
    .pop       (dout_ready),
    .data      (dout),
    .valid     (dout_valid),
    .overrun   (overrun)
  );

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial frame receiver: the far end of a 1-bit, one-bit-per-clock serial line driven by a flop-based transmitter or stimulus source. It detects a start bit, shifts in DATA_W data bits MSB first, checks even parity and the stop bit, and presents each good word on a valid/ready output port with a one-entry holding buffer. It sits between the serial line and any parallel consumer, and reports parity, framing and overrun errors as single-cycle pulses.

## Interface
- DATA_W, 8, data bits per frame (2..32)
- PARITY_EN, 1, 1 = parity bit present and checked; 0 = no parity bit in the frame
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  reset: asynchronous, active-high; one clock; the polarity and synchronicity are fixed
- din  input  1  serial line, idles at 0, sampled once per rising edge
- dout  output  DATA_W  received word, stable while dout_valid is 1
- dout_valid  output  1  holding buffer full
- dout_ready  input  1  consumer accepts dout when dout_valid and dout_ready are both 1 at an edge
- parity_err  output  1  one-cycle pulse: parity mismatch, frame dropped
- frame_err  output  1  one-cycle pulse: stop bit was 1, frame dropped
- overrun  output  1  one-cycle pulse: good frame arrived while buffer full and not popped, frame dropped
- busy  output  1  1 while the FSM is outside IDLE

## Operation
- Frame on din: start (1), DATA_W data bits MSB first, parity (only if PARITY_EN), stop (0).
- Even parity: XOR over the data bits and the parity bit equals 0.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: din=1 -> DATA and clear the bit counter; din=0 -> stay in IDLE.
  - DATA: shift din in at the LSB end, increment the counter; after DATA_W bits -> PARITY if PARITY_EN, else STOP.
  - PARITY: capture the parity bit -> STOP.
  - STOP: evaluate the frame -> IDLE.
- Evaluation priority in STOP: frame_err (din=1), then parity_err, then overrun, otherwise load the buffer. Exactly one of these four outcomes per frame.
- Buffer load is allowed when the buffer is empty, or when it is full and popped at the same edge (simultaneous pop and load keeps dout_valid at 1 and replaces dout).
- Bad or overrun frames never modify dout or dout_valid.
- A din=1 on the stop bit does not start a new frame. The FSM returns to IDLE and samples din afresh on the next edge.

## Timing
- Reset values: dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, counter=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately and discards any held word.
- With the start bit sampled at edge E:
  - data bits are sampled at E+1..E+DATA_W;
  - parity at E+DATA_W+1;
  - stop at E+DATA_W+1+PARITY_EN.
- dout_valid and the error pulses are registered at the stop edge: visible 0 cycles after the stop edge, held for exactly one cycle (pulses).
- Frame length is DATA_W+2+PARITY_EN cycles. Back-to-back frames are supported: a start bit may be sampled at the edge after the stop edge.
- busy rises after edge E and falls after the stop edge.
- dout_ready has no combinational path to any output.

## Structure
- Package serial_frame_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - START_BIT=1'b1, STOP_BIT=1'b0, IDLE_LEVEL=1'b0;
  - a bit-counter width function of DATA_W.
- Sub-module serial_frame_obuf: one-entry valid/ready holding register with load/pop inputs and an overrun output; the top instantiates it once.
- Top holds the FSM, shift register, bit counter, running parity and error pulse registers.

## Test plan
- Reset, then frame 0xA5 (din 1,1,0,1,0,0,1,0,1,0,0), dout_ready=1 -> dout=0xA5, dout_valid high one cycle, no error pulses.
- Frame 0x01 with parity bit 0 -> parity_err one cycle, dout_valid stays 0.
- Frame 0x3C with stop bit 1 -> frame_err one cycle; din=0 on the next edge keeps the FSM in IDLE.
- dout_ready=0, frames 0x11 then 0x22 back-to-back -> dout=0x11 held, overrun pulse at the second stop edge; then dout_ready=1 -> 0x11 popped, dout_valid=0.
- Buffer holds 0x11 and dout_ready=1 exactly at the stop edge of 0x22 -> dout=0x22, dout_valid stays 1, no overrun.
- rst pulsed after the 4th data bit of 0xFF, then a full frame 0x5A -> all outputs 0 during reset, then dout=0x5A with no error pulses.
